// File: rtl/pipelined_mux_tree.sv
// N:1 mux as a registered binary tree of 2:1 stages; valid and channel tag ride with the data.
// Select comes from the external sel or an internal round-robin scan counter.
module pipelined_mux_tree #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [(2**SEL_W)*DATA_W-1:0]   in_data,
  input  logic [SEL_W-1:0]               sel,
  input  logic                           mode,
  input  logic                           in_valid,
  input  logic                           stall,
  output logic [DATA_W-1:0]              out_data,
  output logic                           out_valid,
  output logic [SEL_W-1:0]               out_ch
);

  localparam int N_CH = 2**SEL_W;

  logic [SEL_W-1:0]            r_scan;
  logic [SEL_W-1:0]            w_eff_sel;
  logic [(N_CH-1)*DATA_W-1:0]  w_tree;
  logic [SEL_W-1:0]            w_vld;
  logic [SEL_W-1:0]            w_tag [SEL_W];

  assign w_eff_sel = mode ? r_scan : sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan <= '0;
    end else if (!stall && in_valid && mode) begin
      r_scan <= r_scan + 1'b1;
    end
  end

  // Tree nodes are packed level by level into w_tree: level l starts at node N_CH - 2*(N_CH>>(l+1)).
  for (genvar l = 0; l < SEL_W; l++) begin : g_lvl
    localparam int CNT   = N_CH >> (l + 1);
    localparam int BASE  = N_CH - 2 * CNT;
    localparam int PBASE = N_CH - 4 * CNT;

    logic             r_vld;
    logic [SEL_W-1:0] r_tag;
    logic             w_vld_in;
    logic [SEL_W-1:0] w_tag_in;
    logic             w_sel_bit;

    if (l == 0) begin : g_src
      assign w_vld_in = in_valid;
      assign w_tag_in = w_eff_sel;
    end else begin : g_pipe
      assign w_vld_in = w_vld[l-1];
      assign w_tag_in = w_tag[l-1];
    end

    assign w_sel_bit = w_tag_in[l];

    // Data and tag only load on a valid sample so the outputs hold across bubbles.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_tag <= '0;
      end else if (!stall) begin
        r_vld <= w_vld_in;
        if (w_vld_in) begin
          r_tag <= w_tag_in;
        end
      end
    end

    assign w_vld[l] = r_vld;
    assign w_tag[l] = r_tag;

    for (genvar j = 0; j < CNT; j++) begin : g_node
      logic [DATA_W-1:0] r_data;
      logic [DATA_W-1:0] w_a;
      logic [DATA_W-1:0] w_b;

      if (l == 0) begin : g_leaf
        assign w_a = in_data[(2*j)*DATA_W +: DATA_W];
        assign w_b = in_data[(2*j+1)*DATA_W +: DATA_W];
      end else begin : g_inner
        assign w_a = w_tree[(PBASE+2*j)*DATA_W +: DATA_W];
        assign w_b = w_tree[(PBASE+2*j+1)*DATA_W +: DATA_W];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_data <= '0;
        end else if (!stall && w_vld_in) begin
          r_data <= w_sel_bit ? w_b : w_a;
        end
      end

      assign w_tree[(BASE+j)*DATA_W +: DATA_W] = r_data;
    end
  end

  assign out_data  = w_tree[(N_CH-2)*DATA_W +: DATA_W];
  assign out_valid = w_vld[SEL_W-1];
  assign out_ch    = w_tag[SEL_W-1];

endmodule

// File: tb/tb_pipelined_mux_tree.sv
// Directed vector table for the default 4:1 tree, hand sequences for stall/reset/bubbles,
// and a random stream on 2:1 and 8:1 instances against a delay-line reference.
module tb_pipelined_mux_tree;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // default instance
  logic        rst;
  logic [31:0] in_data;
  logic [1:0]  sel;
  logic        mode, in_valid, stall;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_ch;

  pipelined_mux_tree #(.DATA_W(8), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .mode(mode),
    .in_valid(in_valid), .stall(stall), .out_data(out_data),
    .out_valid(out_valid), .out_ch(out_ch)
  );

  // parameter sweep instances
  logic         sw_rst, sw_valid, sw_stall, sw_mode;
  logic [2:0]   sw_sel;
  logic [15:0]  d1;
  logic [127:0] d3;
  logic [7:0]   o1_data;
  logic         o1_valid;
  logic [0:0]   o1_ch;
  logic [15:0]  o3_data;
  logic         o3_valid;
  logic [2:0]   o3_ch;

  pipelined_mux_tree #(.DATA_W(8), .SEL_W(1)) u1 (
    .clk(clk), .rst(sw_rst), .in_data(d1), .sel(sw_sel[0:0]), .mode(sw_mode),
    .in_valid(sw_valid), .stall(sw_stall), .out_data(o1_data),
    .out_valid(o1_valid), .out_ch(o1_ch)
  );

  pipelined_mux_tree #(.DATA_W(16), .SEL_W(3)) u3 (
    .clk(clk), .rst(sw_rst), .in_data(d3), .sel(sw_sel), .mode(sw_mode),
    .in_valid(sw_valid), .stall(sw_stall), .out_data(o3_data),
    .out_valid(o3_valid), .out_ch(o3_ch)
  );

  typedef struct {
    logic       r;
    logic       v;
    logic       st;
    logic       m;
    logic [1:0] s;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] ec;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t t, input string nm);
    rst      = t.r;
    in_valid = t.v;
    stall    = t.st;
    mode     = t.m;
    sel      = t.s;
    step();
    chk({nm, "_valid"}, 32'(out_valid), 32'(t.ev));
    chk({nm, "_data"},  32'(out_data),  32'(t.ed));
    chk({nm, "_ch"},    32'(out_ch),    32'(t.ec));
  endtask

  // reference state for the sweep
  logic        m1v;
  logic [7:0]  e1d;
  logic [0:0]  e1c, scan1, eff1;
  logic        m3v [3];
  logic [15:0] m3d [3];
  logic [2:0]  m3c [3];
  logic [15:0] e3d;
  logic [2:0]  e3c, scan3, eff3;

  initial begin
    rst = 1'b1; in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0}; sel = 2'd0;
    mode = 1'b0; in_valid = 1'b0; stall = 1'b0;
    sw_rst = 1'b1; sw_valid = 1'b0; sw_stall = 1'b0; sw_mode = 1'b0;
    sw_sel = 3'd0; d1 = '0; d3 = '0;

    //        rst   v     st    m     s       ev    ed      ec
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0,   1'b0, 8'h00, 2'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0,   1'b0, 8'h00, 2'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1,   1'b1, 8'hA0, 2'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2,   1'b1, 8'hB1, 2'd1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd3,   1'b1, 8'hC2, 2'd2};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0,   1'b1, 8'hD3, 2'd3};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0,   1'b0, 8'hD3, 2'd3};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3,   1'b0, 8'hD3, 2'd3};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3,   1'b1, 8'hA0, 2'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0,   1'b1, 8'hB1, 2'd1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1,   1'b1, 8'hC2, 2'd2};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2,   1'b1, 8'hD3, 2'd3};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3,   1'b1, 8'hA0, 2'd0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0,   1'b1, 8'hB1, 2'd1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0,   1'b0, 8'hB1, 2'd1};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1,   1'b0, 8'hB1, 2'd1};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0,   1'b1, 8'hB1, 2'd1};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0,   1'b1, 8'hC2, 2'd2};

    step();
    for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("row%0d", i));

    // stall mid auto-stream: scan is at 3 here
    apply('{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 8'hC2, 2'd2}, "stall_pre0");
    apply('{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 8'hD3, 2'd3}, "stall_pre1");
    for (int i = 0; i < 3; i++)
      apply('{1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 8'hD3, 2'd3}, $sformatf("stall_hold%0d", i));
    apply('{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 8'hA0, 2'd0}, "stall_res0");
    apply('{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 8'hB1, 2'd1}, "stall_res1");
    apply('{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'hB1, 2'd1}, "stall_res2");

    // reset with a sample in flight
    apply('{1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 8'hB1, 2'd1}, "rst_acc");
    apply('{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 8'h00, 2'd0}, "rst_edge");
    apply('{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 2'd0}, "rst_post0");
    apply('{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 2'd0}, "rst_post1");
    apply('{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 8'hA0, 2'd0}, "rst_scan0");
    apply('{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'hA0, 2'd0}, "rst_scan1");

    // bubbles with sel changed right after each accept
    apply('{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 8'hA0, 2'd0}, "bub0");
    apply('{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 8'hC2, 2'd2}, "bub1");
    apply('{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 8'hC2, 2'd2}, "bub2");
    apply('{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 8'hB1, 2'd1}, "bub3");
    apply('{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'hB1, 2'd1}, "bub4");

    // parameter sweep: SEL_W=1 and SEL_W=3/DATA_W=16
    sw_rst = 1'b1;
    step();
    m1v = 1'b0; e1d = '0; e1c = '0; scan1 = '0;
    for (int i = 0; i < 3; i++) begin m3v[i] = 1'b0; m3d[i] = '0; m3c[i] = '0; end
    e3d = '0; e3c = '0; scan3 = '0;
    chk("sw_rst_u1_valid", 32'(o1_valid), 32'(1'b0));
    chk("sw_rst_u3_valid", 32'(o3_valid), 32'(1'b0));
    chk("sw_rst_u3_data",  32'(o3_data),  32'(16'h0));
    sw_rst = 1'b0;

    for (int n = 0; n < 300; n++) begin
      sw_valid = ($urandom_range(0, 3) != 0);
      sw_stall = ($urandom_range(0, 4) == 0);
      sw_mode  = ($urandom_range(0, 2) != 0);
      sw_sel   = 3'($urandom_range(0, 7));
      d1       = 16'($urandom());
      d3       = {$urandom(), $urandom(), $urandom(), $urandom()};

      if (!sw_stall) begin
        eff1 = sw_mode ? scan1 : sw_sel[0:0];
        m1v  = sw_valid;
        if (sw_valid) begin
          e1d = d1[int'(eff1)*8 +: 8];
          e1c = eff1;
          if (sw_mode) scan1 = scan1 + 1'b1;
        end

        for (int k = 2; k > 0; k--) begin
          m3v[k] = m3v[k-1]; m3d[k] = m3d[k-1]; m3c[k] = m3c[k-1];
        end
        eff3   = sw_mode ? scan3 : sw_sel;
        m3v[0] = sw_valid;
        m3d[0] = d3[int'(eff3)*16 +: 16];
        m3c[0] = eff3;
        if (sw_valid && sw_mode) scan3 = scan3 + 3'd1;
        if (m3v[2]) begin e3d = m3d[2]; e3c = m3c[2]; end
      end

      step();
      chk($sformatf("u1_valid_%0d", n), 32'(o1_valid), 32'(m1v));
      chk($sformatf("u1_data_%0d", n),  32'(o1_data),  32'(e1d));
      chk($sformatf("u1_ch_%0d", n),    32'(o1_ch),    32'(e1c));
      chk($sformatf("u3_valid_%0d", n), 32'(o3_valid), 32'(m3v[2]));
      chk($sformatf("u3_data_%0d", n),  32'(o3_data),  32'(e3d));
      chk($sformatf("u3_ch_%0d", n),    32'(o3_ch),    32'(e3c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_mux_tree.md
Name: pipelined_mux_tree

Overview:
- Parametrised N:1 multiplexer for DATA_W-bit data, built as a binary tree of 2:1 stages.
- Each tree level is a register stage; a valid bit and a channel tag travel with the data.
- Two select modes: manual (external select) and auto-scan (internal round-robin channel counter).
- Sits between the multi-channel sample sources and the single shared downstream consumer; generalises the team's fixed 4:1 tree of 2:1 muxes.

Parameters:
- DATA_W, 8, width of each channel and of the output.
- SEL_W, 2, select width; channel count N_CH = 2**SEL_W; tree depth = SEL_W levels (SEL_W >= 1).

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N_CH*DATA_W  packed channels; channel k occupies bits [k*DATA_W +: DATA_W].
- sel  input  SEL_W  channel select in manual mode; ignored in auto mode.
- mode  input  1  0 = manual, 1 = auto-scan.
- in_valid  input  1  sample presented this cycle.
- stall  input  1  holds the entire pipeline and the scan counter.
- out_data  output  DATA_W  selected channel data.
- out_valid  output  1  out_data/out_ch valid.
- out_ch  output  SEL_W  channel index that produced out_data.

Behaviour:
- Reset (rst=1 at a clk edge): out_data=0, out_valid=0, out_ch=0. All internal stage registers, valid bits and tags cleared. Scan counter cleared to 0.
- rst has priority over stall and in_valid. Reset mid-operation discards all in-flight samples; no out_valid is produced for them.
- Effective select eff_sel = (mode ? scan_cnt : sel), sampled in the cycle in_valid=1 and stall=0.
- Level 1 registers N_CH/2 pair results. Pair j selects between channel 2j and channel 2j+1 using eff_sel[0]. Level L uses eff_sel[L-1]; the higher select bits are carried forward in a registered pipe alongside the data.
- The final level drives the out_* registers.
- Latency: exactly SEL_W cycles from acceptance to output, i.e. SEL_W clk edges with stall=0.
- Accepting a sample (in_valid=1, stall=0) launches valid=1 and tag=eff_sel into level 1. With in_valid=0, a bubble (valid=0) is launched; data registers may update but are don't-care.
- Throughput: one sample per cycle, no gaps required.
- out_valid is the registered valid bit of the last level. out_data and out_ch hold their last values while out_valid=0.
- stall=1: every stage register, every valid bit and scan_cnt hold. in_valid is ignored and nothing is accepted. out_* stay constant.
- Auto-scan:
  - scan_cnt increments by 1 on each accepted sample while mode=1.
  - Wraps from N_CH-1 to 0.
  - Holds when mode=0; it is not reset by a mode change.
- Mode switch: takes effect on the next accepted sample. In-flight samples keep the select and tag latched at acceptance.
- Select and tag are never re-sampled mid-tree: a sel change while samples are in flight does not affect them.
- Purely registered outputs; no combinational path from inputs to outputs.

Test Plan:
- Defaults (DATA_W=8, SEL_W=2), in_data = {8'hD3,8'hC2,8'hB1,8'hA0}, mode=0. Sweep sel=0,1,2,3 on consecutive cycles with in_valid=1 -> starting 2 cycles after the first, out_data = A0,B1,C2,D3 and out_ch = 0,1,2,3 back-to-back, with out_valid=1 for 4 cycles.
- mode=1, in_valid=1 for 6 cycles -> out_ch sequence 0,1,2,3,0,1 (wrap) with matching data A0,B1,C2,D3,A0,B1.
- Stall: start the auto stream, raise stall for 3 cycles mid-stream -> out_* frozen for 3 cycles, then the sequence resumes with no channel skipped or repeated.
- Reset mid-flight: accept sel=3, assert rst on the next edge -> out_valid never pulses for that sample; out_data=0, out_ch=0; scan_cnt restarts at 0.
- Bubbles and sel change in flight: in_valid pattern 1,0,1 with sel 2,X,1, and sel changed on the cycle after each accept -> outputs C2, gap (out_valid=0), B1 with tags 2,1.
- Parameter sweep: SEL_W=1 (latency 1) and SEL_W=3, DATA_W=16 (latency 3, 8 channels) -> random stream checked against a reference model.
